// File: rtl/demux2_stream.sv
// demux2_stream
// -------------
// Registered 1-to-2 stream demultiplexer. A single producer offers words on
// a valid/ready stream together with a per-word select bit; each accepted
// word is parked in a one-entry output register and presented on exactly one
// of two consumer channels. Per-port wrapping delivery counters are provided
// for bring-up.
//
// Parameters
//   WIDTH    data word width in bits
//   CNT_W    width of each delivery counter
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RESET      synchronous active-high reset
//   I_data     input word
//   I_valid    input word present
//   I_ready    block can take a word this cycle
//   S          select, captured with I_data (1 -> port 0, 0 -> port 1)
//   O0_data    port 0 word (zero when O0_valid is low)
//   O0_valid   port 0 word present
//   O0_ready   port 0 consumer accepts
//   O1_data    port 1 word (zero when O1_valid is low)
//   O1_valid   port 1 word present
//   O1_ready   port 1 consumer accepts
//   count0     words delivered on port 0, wrapping
//   count1     words delivered on port 1, wrapping

module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic             S,
  output logic [WIDTH-1:0] O0_data,
  output logic             O0_valid,
  input  logic             O0_ready,
  output logic [WIDTH-1:0] O1_data,
  output logic             O1_valid,
  input  logic             O1_ready,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  // dest == 0 means the held word belongs to port 0
  logic             full;
  logic             dest;
  logic [WIDTH-1:0] hold;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  logic fire0;
  logic fire1;
  logic out_fire;
  logic in_fire;

  // Output decode: only the destination port sees the held word, the other
  // port is driven to zero so no stale data is ever visible.
  always_comb begin
    O0_valid = full & ~dest;
    O1_valid = full & dest;
    O0_data  = O0_valid ? hold : '0;
    O1_data  = O1_valid ? hold : '0;
  end

  // Handshake decode. Only the destination port's ready can drain the
  // register, so I_ready depends combinationally on that port alone; a word
  // leaving and a new one arriving in the same cycle gives full throughput.
  always_comb begin
    fire0    = O0_valid & O0_ready;
    fire1    = O1_valid & O1_ready;
    out_fire = fire0 | fire1;
    I_ready  = ~full | out_fire;
    in_fire  = I_valid & I_ready;
  end

  // Output register. A new accept takes priority over a drain so that a
  // simultaneous accept/drain refills the slot without a bubble. On a plain
  // drain hold/dest are left alone; they are masked by full anyway.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      full <= 1'b0;
      dest <= 1'b0;
      hold <= '0;
    end else if (in_fire) begin
      hold <= I_data;
      dest <= ~S;
      full <= 1'b1;
    end else if (out_fire) begin
      full <= 1'b0;
    end
  end

  // Delivery counters, natural modulo-2^CNT_W wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (fire0) cnt0 <= cnt0 + 1'b1;
      if (fire1) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign count0 = cnt0;
  assign count1 = cnt1;

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream
// ----------------
// Self-checking bench for demux2_stream. A behavioural reference model keeps
// the words in flight as a small queue of (data, port) entries and per-port
// lists of words still owed to each consumer; every cycle the DUT outputs are
// compared against what that model predicts. Directed sequences exercise
// reset, steering, backpressure, streaming, counter wrap and mid-transfer
// reset, followed by a randomized phase.

module tb_demux2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [WIDTH-1:0] I_data = '0;
  logic             I_valid = 1'b0;
  logic             I_ready;
  logic             S = 1'b0;
  logic [WIDTH-1:0] O0_data;
  logic             O0_valid;
  logic             O0_ready = 1'b0;
  logic [WIDTH-1:0] O1_data;
  logic             O1_valid;
  logic             O1_ready = 1'b0;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  always #5 CLK = ~CLK;

  demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .I_data   (I_data),
    .I_valid  (I_valid),
    .I_ready  (I_ready),
    .S        (S),
    .O0_data  (O0_data),
    .O0_valid (O0_valid),
    .O0_ready (O0_ready),
    .O1_data  (O1_data),
    .O1_valid (O1_valid),
    .O1_ready (O1_ready),
    .count0   (count0),
    .count1   (count1)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               port;
  } word_t;

  // Reference model state
  word_t            inflight[$];
  logic [WIDTH-1:0] owed0[$];
  logic [WIDTH-1:0] owed1[$];
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;
  bit               m_known = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare DUT outputs with the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic s,
                               input logic r0, input logic r1,
                               input logic [WIDTH-1:0] d);
    bit               full;
    bit               port;
    bit               exp_ir;
    bit               e0v;
    bit               e1v;
    bit               leaving;
    logic [WIDTH-1:0] hd;
    word_t            w;

    @(negedge CLK);
    RESET    = rst;
    I_valid  = v;
    I_data   = d;
    S        = s;
    O0_ready = r0;
    O1_ready = r1;
    #1;

    full   = (inflight.size() != 0);
    port   = full ? inflight[0].port : 1'b0;
    hd     = full ? inflight[0].data : '0;
    e0v    = full && !port;
    e1v    = full && port;
    exp_ir = !full || (port ? r1 : r0);

    if (m_known) begin
      checkOutput("I_ready",  32'(I_ready),  32'(exp_ir));
      checkOutput("O0_valid", 32'(O0_valid), 32'(e0v));
      checkOutput("O1_valid", 32'(O1_valid), 32'(e1v));
      checkOutput("O0_data",  32'(O0_data),  e0v ? 32'(hd) : 32'd0);
      checkOutput("O1_data",  32'(O1_data),  e1v ? 32'(hd) : 32'd0);
      checkOutput("count0",   32'(count0),   32'(m_cnt0));
      checkOutput("count1",   32'(count1),   32'(m_cnt1));
      if (!rst) begin
        if (O0_valid === 1'b1 && r0) begin
          if (owed0.size() == 0) checkOutput("extra_word0", 32'd1, 32'd0);
          else                   checkOutput("order0", 32'(O0_data), 32'(owed0.pop_front()));
        end
        if (O1_valid === 1'b1 && r1) begin
          if (owed1.size() == 0) checkOutput("extra_word1", 32'd1, 32'd0);
          else                   checkOutput("order1", 32'(O1_data), 32'(owed1.pop_front()));
        end
      end
    end

    @(posedge CLK);
    if (rst) begin
      inflight.delete();
      owed0.delete();
      owed1.delete();
      m_cnt0  = '0;
      m_cnt1  = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      leaving = full && (port ? r1 : r0);
      if (leaving) begin
        if (port) m_cnt1++;
        else      m_cnt0++;
        void'(inflight.pop_front());
      end
      if (v && exp_ir) begin
        w.data = d;
        w.port = ~s;
        inflight.push_back(w);
        if (s) owed0.push_back(d);
        else   owed1.push_back(d);
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, r0, r1, '0);
  endtask

  task automatic expectCounts(input string tag, input int e0, input int e1);
    #2;
    checkOutput({tag, "_count0"}, 32'(count0), 32'(e0));
    checkOutput({tag, "_count1"}, 32'(count1), 32'(e1));
  endtask

  initial begin
    // Reset held two cycles with a word offered: nothing may be captured
    doReset();
    #2;
    checkOutput("rst_O0_valid", 32'(O0_valid), 32'd0);
    checkOutput("rst_O1_valid", 32'(O1_valid), 32'd0);
    checkOutput("rst_I_ready",  32'(I_ready),  32'd1);
    expectCounts("rst", 0, 0);

    // Steering: 0xA5 to port 0, 0x3C to port 1
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    idle(2, 1'b1, 1'b1);
    expectCounts("steer", 1, 1);

    // Backpressure on port 0 while a port-1 word waits
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
    #2;
    checkOutput("bp_hold_data", 32'(O0_data), 32'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22);
    #2;
    checkOutput("bp_pass_data", 32'(O1_data), 32'h22);
    idle(2, 1'b1, 1'b1);
    expectCounts("bp", 1, 1);

    // Streaming 16 words, alternating destination
    doReset();
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b1, (i % 2) == 0, 1'b1, 1'b1, 8'(i));
    idle(2, 1'b1, 1'b1);
    expectCounts("stream", 8, 8);

    // Counter wrap on port 1
    doReset();
    for (int i = 0; i < 257; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'(i));
    idle(2, 1'b1, 1'b1);
    expectCounts("wrap", 0, 1);

    // Reset while 0x77 is stalled on port 1
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    idle(2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    #2;
    checkOutput("midrst_O1_valid", 32'(O1_valid), 32'd0);
    idle(3, 1'b1, 1'b1);
    expectCounts("midrst", 0, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 500; i++)
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom));

    // Drain and make sure every owed word came out
    idle(3, 1'b1, 1'b1);
    checkOutput("drain_owed0", 32'(owed0.size()), 32'd0);
    checkOutput("drain_owed1", 32'(owed1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer: the steering counterpart of the 2:1 bit multiplexer (`Mux2xBit`/`basic_if`) path. It accepts a valid/ready word stream plus a per-word select bit and delivers each word to exactly one of two output channels through a single-entry output register. It sits between a single producer and two consumers. Per-port delivery counters support bring-up and verification.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 8, width of each delivery counter (≥1)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- I_data  input  WIDTH  input word
- I_valid  input  1  input word present
- I_ready  output  1  block can accept input this cycle
- S  input  1  select, sampled with I_data on accept; S=1 → port 0, S=0 → port 1 (same polarity as the 2:1 mux: S=1 picks I[0])
- O0_data  output  WIDTH  port 0 word
- O0_valid  output  1  port 0 word present
- O0_ready  input  1  port 0 consumer accepts
- O1_data  output  WIDTH  port 1 word
- O1_valid  output  1  port 1 word present
- O1_ready  input  1  port 1 consumer accepts
- count0  output  CNT_W  words delivered on port 0, wrapping
- count1  output  CNT_W  words delivered on port 1, wrapping

## Operation
- State: `full` (1b), `dest` (1b), `hold` (WIDTH), `cnt0`, `cnt1` (CNT_W each).
- `dest` = 0 means port 0.
- O0_valid = full & (dest==0).
- O1_valid = full & (dest==1).
- Ox_data = hold when Ox_valid; otherwise 0 (inactive port data is forced to zero, never stale).
- `out_fire` = (O0_valid & O0_ready) | (O1_valid & O1_ready).
- I_ready = ~full | out_fire. This path is combinational from Ox_ready of the destination port only.
- `in_fire` = I_valid & I_ready.
- Register update priority per cycle:
  - RESET: full=0, dest=0, hold=0, cnt0=cnt1=0.
  - else in_fire: hold ← I_data, dest ← ~S, full ← 1. Covers simultaneous out_fire (pass-through, no bubble).
  - else out_fire: full ← 0. hold and dest keep their values but are not visible.
- Counters: cnt0 += 1 on O0_valid & O0_ready; cnt1 += 1 on O1_valid & O1_ready. Modulo 2^CNT_W; all-ones wraps to 0.
- Ready on the non-destination port is ignored and never drains the register.
- Words are never duplicated, dropped (except by RESET), or reordered.
- I_data and S are don't-care when I_valid=0.

## Timing
- Reset values: I_ready=1 (as soon as RESET deasserts; during RESET the register is empty), O0_valid=O1_valid=0, O0_data=O1_data=0, count0=count1=0.
- Latency: word accepted at edge N is on Ox_valid/Ox_data in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle when the destination consumer holds ready high. Alternating destinations also sustain 1 word/cycle.
- Backpressure: while the held word's destination ready=0, I_ready=0 and the held word stays stable (valid, data, dest unchanged).
- Ox_valid never deasserts without a handshake, except on RESET.
- RESET mid-transfer: held word discarded; outputs reach reset values the cycle after the RESET edge.
- Counter value reflects handshakes up to the previous edge (registered).

## Test plan
- Reset: assert RESET 2 cycles with I_valid=1 → O0_valid=O1_valid=0, count0=count1=0, no word captured; I_ready=1 the first cycle after release.
- Steering: send 0xA5 with S=1, then 0x3C with S=0, both ports ready → 0xA5 on O0 in cycle 1, 0x3C on O1 in cycle 2; O1_data=0 while O0 valid; count0=1, count1=1.
- Backpressure: send 0x11 (S=1) with O0_ready=0 for 3 cycles, and O1_ready=1 throughout → O0 holds 0x11, I_ready=0, second word 0x22 (S=0) is not accepted until the cycle O0_ready rises. Then 0x22 appears on O1 the next cycle with no bubble.
- Streaming: 16 back-to-back words 0x00..0x0F, S alternating, both ready → one delivery per cycle in order; count0=8, count1=8.
- Wrap: CNT_W=8, deliver 257 words to port 1 → count1=1, count0=0.
- Reset mid-operation: word 0x77 held with O1_ready=0, then RESET pulse → O1_valid=0 after the edge, 0x77 never delivered, counters 0.
